// File: rtl/vfu_queue_pkg.sv
// Shared types for the VFU slot request queue: request layout, tag type and
// the conversion helpers between the packed bus and the structured view.
package vfu_queue_pkg;

  localparam int CREDITS_W = 4;
  localparam int REQ_W     = 204;

  typedef logic [1:0] tag_t;

  // Field order is MSB first; widths sum to REQ_W.
  typedef struct packed {
    logic [31:0] src0;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] src3;
    logic [7:0]  opcode;
    logic [31:0] mask;
    logic [7:0]  flags;
    logic [1:0]  vsew;
    logic [3:0]  shifter_size;
    logic [7:0]  pop_init;
    logic [4:0]  group_index;
    logic [2:0]  lane_index;
    logic [3:0]  unit_select;
    logic [1:0]  rounding_mode;
  } vfu_req_t;

  function automatic logic [REQ_W-1:0] pack_req(input vfu_req_t r);
    return r;
  endfunction

  function automatic vfu_req_t unpack_req(input logic [REQ_W-1:0] b);
    return vfu_req_t'(b);
  endfunction

endpackage

// File: rtl/vfu_req_fifo.sv
// Generic DEPTH x W circular FIFO with explicit count and flush.
// Pointers wrap at DEPTH, so any DEPTH >= 2 is valid.
module vfu_req_fifo
  import vfu_queue_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq,
  input  logic [W-1:0]     enq_data,
  input  logic             deq,
  input  logic             flush,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A flush drops any write presented in the same cycle.
  assign wr_en = enq && !flush && (count_q != CNT_W'(DEPTH));
  assign rd_en = deq && !flush && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (wr_en) begin
        wr_ptr_d        = ptr_next(wr_ptr_q);
        mem_d[wr_ptr_q] = enq_data;
      end
      if (rd_en) rd_ptr_d = ptr_next(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only and needs no reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/vfu_slot_request_queue.sv
// Request queue between the slot arbiter and a VFU: buffers requests, meters
// issue against VFU credits and blocks issue of tags that are still in flight.
module vfu_slot_request_queue
  import vfu_queue_pkg::*;
#(
  parameter int PAYLOAD_W = 204,
  parameter int TAG_W     = 2,
  parameter int DEPTH     = 2,
  parameter int CREDITS   = 4,
  localparam int NUM_TAGS = 2 ** TAG_W,
  localparam int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [TAG_W-1:0]     out_tag,
  input  logic                 resp_valid,
  input  logic [TAG_W-1:0]     resp_tag,
  input  logic                 flush,
  output logic [NUM_TAGS-1:0]  busy_tags,
  output logic [CREDITS_W-1:0] credits,
  output logic [OCC_W-1:0]     occupancy,
  output logic                 err_spurious_resp
);

  logic [PAYLOAD_W+TAG_W-1:0] head_data;
  logic [OCC_W-1:0]           occ;
  logic                       enq_fire;
  logic                       issue_fire;
  logic                       resp_spurious;
  logic                       resp_retire;

  logic [NUM_TAGS-1:0]  busy_q, busy_d;
  logic [CREDITS_W-1:0] credits_q, credits_d;
  logic                 err_q, err_d;

  // in_ready looks only at registered occupancy: no path from out_ready.
  assign in_ready = (occ != OCC_W'(DEPTH));
  assign enq_fire = in_valid && in_ready;

  vfu_req_fifo #(
    .W     (PAYLOAD_W + TAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq       (enq_fire),
    .enq_data  ({in_tag, in_payload}),
    .deq       (issue_fire),
    .flush     (flush),
    .head_data (head_data),
    .count     (occ)
  );

  assign out_payload = head_data[PAYLOAD_W-1:0];
  assign out_tag     = head_data[PAYLOAD_W +: TAG_W];

  // Flush is the only input that can drop out_valid without a fire.
  assign out_valid  = (occ != '0) && (credits_q != '0) && !busy_q[out_tag] && !flush;
  assign issue_fire = out_valid && out_ready;

  assign resp_spurious = resp_valid && !busy_q[resp_tag];
  assign resp_retire   = resp_valid && busy_q[resp_tag];

  always_comb begin
    busy_d = busy_q;
    if (resp_valid) busy_d[resp_tag] = 1'b0;
    // Issue is applied after the clear so reuse of the same tag stays busy.
    if (issue_fire) busy_d[out_tag] = 1'b1;

    credits_d = credits_q;
    if (issue_fire && !resp_retire) begin
      credits_d = credits_q - CREDITS_W'(1);
    end else if (resp_retire && !issue_fire && (credits_q != CREDITS_W'(CREDITS))) begin
      credits_d = credits_q + CREDITS_W'(1);
    end

    err_d = err_q || resp_spurious;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q    <= '0;
      credits_q <= CREDITS_W'(CREDITS);
      err_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign busy_tags         = busy_q;
  assign credits           = credits_q;
  assign occupancy         = occ;
  assign err_spurious_resp = err_q;

endmodule

// File: tb/tb_vfu_slot_request_queue.sv
// Bench for vfu_slot_request_queue: a cycle table of stimulus with hand-derived
// control expectations, plus a payload scoreboard and a mid-burst reset sequence.
module tb_vfu_slot_request_queue;

  localparam int PW = 204;
  localparam int NV = 41;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_payload;
  logic [1:0]    in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_payload;
  logic [1:0]    out_tag;
  logic          resp_valid;
  logic [1:0]    resp_tag;
  logic          flush;
  logic [3:0]    busy_tags;
  logic [3:0]    credits;
  logic [1:0]    occupancy;
  logic          err_spurious_resp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       iv;
    logic [1:0] it;
    logic       ord;
    logic       rv;
    logic [1:0] rt;
    logic       fl;
    logic       e_ov;
    logic       e_ir;
    logic [3:0] e_cr;
    logic [3:0] e_busy;
    logic [1:0] e_occ;
    logic       e_err;
  } vec_t;

  typedef struct {
    logic [1:0]    tag;
    logic [PW-1:0] payload;
  } sb_t;

  vec_t vecs [NV];
  sb_t  sb_q [$];

  vfu_slot_request_queue dut (
    .clock             (clock),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_payload        (in_payload),
    .in_tag            (in_tag),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_payload       (out_payload),
    .out_tag           (out_tag),
    .resp_valid        (resp_valid),
    .resp_tag          (resp_tag),
    .flush             (flush),
    .busy_tags         (busy_tags),
    .credits           (credits),
    .occupancy         (occupancy),
    .err_spurious_resp (err_spurious_resp)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t v(input int iv, it, ord, rv, rt, fl,
                             input int ov, ir, cr, busy, occ, err);
    vec_t r;
    r.iv = 1'(iv); r.it = 2'(it); r.ord = 1'(ord);
    r.rv = 1'(rv); r.rt = 2'(rt); r.fl = 1'(fl);
    r.e_ov = 1'(ov); r.e_ir = 1'(ir); r.e_cr = 4'(cr);
    r.e_busy = 4'(busy); r.e_occ = 2'(occ); r.e_err = 1'(err);
    return r;
  endfunction

  function automatic logic [PW-1:0] mk_payload(input int n);
    logic [31:0] w;
    w = 32'(n) * 32'h9E37_79B9 + 32'(n);
    return {{6{w}}, 12'h0A5};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Pop and compare one issued request against the scoreboard.
  task automatic sb_check(input int idx);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty_r%0d: got issue of tag %0d required no issue", idx, out_tag);
    end else begin
      e = sb_q.pop_front();
      if (out_tag !== e.tag || out_payload !== e.payload) begin
        errors++;
        $display("FAIL sb_order_r%0d: got tag %0d payload %0h required tag %0d payload %0h",
                 idx, out_tag, out_payload[43:0], e.tag, e.payload[43:0]);
      end
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_tag = '0; in_payload = '0; out_ready = 1'b0;
    resp_valid = 1'b0; resp_tag = '0; flush = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_occ"},   32'(occupancy), 32'd0);
    chk({pfx, "_ov"},    32'(out_valid), 32'd0);
    chk({pfx, "_ir"},    32'(in_ready), 32'd1);
    chk({pfx, "_cr"},    32'(credits), 32'd4);
    chk({pfx, "_busy"},  32'(busy_tags), 32'd0);
    chk({pfx, "_err"},   32'(err_spurious_resp), 32'd0);
  endtask

  initial begin
    // Columns: iv,tag,out_ready,rv,rtag,flush | out_valid,in_ready,credits,busy,occ,err
    vecs[0]  = v(1,1,1,0,0,0, 0,1,4,'h0,0,0);
    vecs[1]  = v(0,0,1,0,0,0, 1,1,4,'h0,1,0);
    vecs[2]  = v(0,0,1,0,0,0, 0,1,3,'h2,0,0);
    vecs[3]  = v(0,0,1,1,1,0, 0,1,3,'h2,0,0);
    vecs[4]  = v(0,0,0,0,0,0, 0,1,4,'h0,0,0);
    vecs[5]  = v(1,0,0,0,0,0, 0,1,4,'h0,0,0);
    vecs[6]  = v(1,1,0,0,0,0, 1,1,4,'h0,1,0);
    vecs[7]  = v(1,2,0,0,0,0, 1,0,4,'h0,2,0);
    vecs[8]  = v(1,2,1,0,0,0, 1,0,4,'h0,2,0);
    vecs[9]  = v(1,2,1,0,0,0, 1,1,3,'h1,1,0);
    vecs[10] = v(0,0,1,0,0,0, 1,1,2,'h3,1,0);
    vecs[11] = v(0,0,0,1,0,0, 0,1,1,'h7,0,0);
    vecs[12] = v(0,0,0,1,1,0, 0,1,2,'h6,0,0);
    vecs[13] = v(1,2,1,0,0,0, 0,1,3,'h4,0,0);
    vecs[14] = v(0,0,1,0,0,0, 0,1,3,'h4,1,0);
    vecs[15] = v(0,0,1,0,0,0, 0,1,3,'h4,1,0);
    vecs[16] = v(0,0,1,1,2,0, 0,1,3,'h4,1,0);
    vecs[17] = v(0,0,1,0,0,0, 1,1,4,'h0,1,0);
    vecs[18] = v(0,0,1,1,2,0, 0,1,3,'h4,0,0);
    vecs[19] = v(1,0,1,0,0,0, 0,1,4,'h0,0,0);
    vecs[20] = v(1,1,1,0,0,0, 1,1,4,'h0,1,0);
    vecs[21] = v(1,2,1,0,0,0, 1,1,3,'h1,1,0);
    vecs[22] = v(1,3,1,0,0,0, 1,1,2,'h3,1,0);
    vecs[23] = v(1,3,1,0,0,0, 1,1,1,'h7,1,0);
    vecs[24] = v(0,0,1,0,0,0, 0,1,0,'hF,1,0);
    vecs[25] = v(0,0,1,1,3,0, 0,1,0,'hF,1,0);
    vecs[26] = v(0,0,1,0,0,0, 1,1,1,'h7,1,0);
    vecs[27] = v(1,0,1,0,0,0, 0,1,0,'hF,0,0);
    vecs[28] = v(1,2,1,0,0,0, 0,1,0,'hF,1,0);
    vecs[29] = v(1,1,1,0,0,1, 0,0,0,'hF,2,0);
    vecs[30] = v(1,2,1,0,0,0, 0,1,0,'hF,0,0);
    vecs[31] = v(1,0,1,0,0,1, 0,1,0,'hF,1,0);
    vecs[32] = v(0,0,1,1,1,0, 0,1,0,'hF,0,0);
    vecs[33] = v(0,0,1,1,0,0, 0,1,1,'hD,0,0);
    vecs[34] = v(1,1,1,1,2,0, 0,1,2,'hC,0,0);
    vecs[35] = v(0,0,1,1,3,0, 1,1,3,'h8,1,0);
    vecs[36] = v(0,0,1,1,1,0, 0,1,3,'h2,0,0);
    vecs[37] = v(0,0,1,1,3,0, 0,1,4,'h0,0,0);
    vecs[38] = v(1,2,1,0,0,0, 0,1,4,'h0,0,1);
    vecs[39] = v(0,0,1,1,2,0, 1,1,4,'h0,1,1);
    vecs[40] = v(0,0,1,0,0,0, 0,1,3,'h4,0,1);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_state("rst");

    for (int i = 0; i < NV; i++) begin
      @(posedge clock);
      #1;
      in_valid   = vecs[i].iv;
      in_tag     = vecs[i].it;
      in_payload = mk_payload(i);
      out_ready  = vecs[i].ord;
      resp_valid = vecs[i].rv;
      resp_tag   = vecs[i].rt;
      flush      = vecs[i].fl;
      @(negedge clock);
      chk($sformatf("r%0d_ov", i),   32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("r%0d_ir", i),   32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("r%0d_cr", i),   32'(credits), 32'(vecs[i].e_cr));
      chk($sformatf("r%0d_busy", i), 32'(busy_tags), 32'(vecs[i].e_busy));
      chk($sformatf("r%0d_occ", i),  32'(occupancy), 32'(vecs[i].e_occ));
      chk($sformatf("r%0d_err", i),  32'(err_spurious_resp), 32'(vecs[i].e_err));
      if (out_valid && out_ready) sb_check(i);
      if (vecs[i].fl) sb_q.delete();
      else if (vecs[i].iv && vecs[i].e_ir)
        sb_q.push_back('{tag: vecs[i].it, payload: mk_payload(i)});
    end

    @(posedge clock);
    #1 idle_inputs();
    @(negedge clock);
    chk("tbl_sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of a burst with traffic on every input.
    @(posedge clock);
    #1 in_valid = 1'b1; in_tag = 2'd0; in_payload = mk_payload(100);
    @(posedge clock);
    #1 in_valid = 1'b1; in_tag = 2'd1; in_payload = mk_payload(101);
    @(posedge clock);
    #1 reset = 1'b1; in_valid = 1'b1; in_tag = 2'd3; out_ready = 1'b1;
    resp_valid = 1'b1; resp_tag = 2'd2;
    @(negedge clock);
    chk("burst_occ", 32'(occupancy), 32'd2);
    chk("burst_ir",  32'(in_ready), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0; idle_inputs();
    sb_q.delete();
    @(negedge clock);
    check_reset_state("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
